// File: rtl/addsub_pkg.sv
// Shared constants and FSM state encoding for the bit-serial adder/subtractor.
package addsub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_cell.sv
// One-bit add/subtract slice: b is inverted when ctrl selects subtract.
module addsub_cell (
    input  logic a,
    input  logic b,
    input  logic ctrl,
    input  logic c,
    output logic sum,
    output logic carry
);

    logic b_eff;

    assign b_eff = b ^ ctrl;
    assign sum   = a ^ b_eff ^ c;
    assign carry = (a & b_eff) | (a & c) | (b_eff & c);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per RUN cycle.
// The DONE cycle publishes the result and may accept the next start back-to-back.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             control_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ctrl_q, ctrl_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             vout_q, vout_d;
    logic             cell_sum;
    logic             cell_carry;

    addsub_cell u_cell (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .ctrl  (ctrl_q),
        .c     (carry_q),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        cout_d   = cout_q;
        vout_d   = vout_q;

        case (state_q)
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {cell_sum, sum_q[WIDTH-1:1]};
                carry_d = cell_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                // Carry into the MSB is carry_q on the last bit; carry out is the cell's.
                if (cnt_q == LAST_BIT) begin
                    ovf_d   = carry_q ^ cell_carry;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                result_d = sum_q;
                cout_d   = carry_q;
                vout_d   = ovf_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start_in && (state_q != RUN)) begin
            a_d     = a_in;
            b_d     = b_in;
            ctrl_d  = control_in;
            carry_d = control_in;
            cnt_d   = '0;
            state_d = RUN;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            ctrl_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            vout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            vout_q   <= vout_d;
        end
    end

    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign result_out   = result_q;
    assign carry_out    = cout_q;
    assign overflow_out = vout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized self-checking bench for serial_addsub against an arithmetic reference model.
module tb_serial_addsub;
    import addsub_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int errors;
    int checks;

    logic [W-1:0] av  [0:63];
    logic [W-1:0] bv  [0:63];
    logic         opv [0:63];

    serial_addsub #(.WIDTH(W)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .start_in     (start),
        .control_in   (ctrl),
        .a_in         (a),
        .b_in         (b),
        .busy_out     (busy),
        .done_out     (done),
        .result_out   (result),
        .carry_out    (cout),
        .overflow_out (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, carry, result} from plain unsigned/signed integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic op);
        int unsigned ux, uy, ures;
        int          sx, sy, sres;
        logic        c, v;
        ux = 32'(x);
        uy = 32'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (op == OP_ADD) begin
            ures = ux + uy;
            c    = (ures >= (32'd1 << W));
            sres = sx + sy;
        end else begin
            ures = ux - uy;
            c    = (ux >= uy);
            sres = sx - sy;
        end
        v = (sres > (2 ** (W - 1)) - 1) || (sres < -(2 ** (W - 1)));
        return {v, c, ures[W-1:0]};
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                          input bit poke);
        logic [W+1:0] e;
        int           dones;
        int           lat;
        int           busy_bad;
        e        = model(x, y, op);
        dones    = 0;
        lat      = -1;
        busy_bad = 0;
        start = 1'b1; a = x; b = y; ctrl = op;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= W + 4; n++) begin
            if (done) begin
                dones++;
                if (lat < 0) lat = n;
            end
            if (busy != (n <= W + 1)) busy_bad++;
            start = poke && (n == 3);
            if (poke && n == 3) begin
                a = ~x; b = x ^ y ^ W'(8'h5a); ctrl = ~op;
            end
            @(negedge clk);
        end
        check("done_count", 32'(dones), 32'd1);
        check("latency", 32'(lat), 32'(W + 2));
        check("busy_window", 32'(busy_bad), 32'd0);
        check("result", 32'(result), 32'(e[W-1:0]));
        check("carry", 32'(cout), 32'(e[W]));
        check("overflow", 32'(ovf), 32'(e[W+1]));
    endtask

    task automatic reset_mid();
        int dones;
        dones = 0;
        start = 1'b1; a = W'(200); b = W'(100); ctrl = OP_ADD;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(cout), 32'd0);
        check("rst_overflow", 32'(ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < W + 4; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_no_done", 32'(dones), 32'd0);
        check("rst_idle_busy", 32'(busy), 32'd0);
    endtask

    // Start held high: captures happen every W+1 edges while operands change every cycle.
    task automatic back_to_back();
        int           dones;
        int           j;
        bit           on_phase;
        logic [W+1:0] e;
        dones = 0;
        for (int i = 0; i < 64; i++) begin
            av[i]  = W'($urandom);
            bv[i]  = W'($urandom);
            opv[i] = 1'($urandom);
        end
        start = 1'b1; a = av[0]; b = bv[0]; ctrl = opv[0];
        for (int m = 0; m < 4 * (W + 1) + 2; m++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dones++;
                on_phase = (m >= W + 1) && (((m - W - 1) % (W + 1)) == 0);
                check("b2b_phase", 32'(on_phase), 32'd1);
                j = (m >= W + 1) ? (m - W - 1) / (W + 1) : 0;
                e = model(av[j * (W + 1)], bv[j * (W + 1)], opv[j * (W + 1)]);
                check("b2b_result", 32'(result), 32'(e[W-1:0]));
                check("b2b_carry", 32'(cout), 32'(e[W]));
                check("b2b_overflow", 32'(ovf), 32'(e[W+1]));
            end
            start = (m + 1 <= 3 * (W + 1));
            a     = av[m + 1];
            b     = bv[m + 1];
            ctrl  = opv[m + 1];
        end
        start = 1'b0;
        check("b2b_dones", 32'(dones), 32'd4);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start  = 1'b0;
        ctrl   = 1'b0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        check("init_busy", 32'(busy), 32'd0);
        check("init_done", 32'(done), 32'd0);
        check("init_result", 32'(result), 32'd0);
        check("init_carry", 32'(cout), 32'd0);
        check("init_overflow", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(W'(100), W'(27), OP_ADD, 1'b0);
        run_op(W'(100), W'(28), OP_ADD, 1'b0);
        run_op(W'(8'hFF), W'(8'h01), OP_ADD, 1'b0);
        run_op(W'(5), W'(7), OP_SUB, 1'b0);
        run_op(W'(8'h3C), W'(8'h51), OP_ADD, 1'b1);
        run_op(W'(8'h80), W'(8'h01), OP_SUB, 1'b0);

        reset_mid();
        run_op(W'(3), W'(4), OP_ADD, 1'b0);

        back_to_back();
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
